// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two requesters, the register-file write port
// and the forwarding lookup. The arbiter sits on the slave side.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5,
    parameter int CW   = 32
);
    logic            req0_valid;
    logic [AW-1:0]   req0_rd;
    logic [XLEN-1:0] req0_data;
    logic            req0_ready;
    logic            req1_valid;
    logic [AW-1:0]   req1_rd;
    logic [XLEN-1:0] req1_data;
    logic            req1_ready;
    logic            rf_we;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic [AW-1:0]   chk_rs;
    logic            chk_hit;
    logic [XLEN-1:0] chk_data;
    logic [CW-1:0]   wr_count;
    logic [CW-1:0]   drop_count;

    modport master (
        output req0_valid, req0_rd, req0_data,
        output req1_valid, req1_rd, req1_data,
        output chk_rs,
        input  req0_ready, req1_ready,
        input  rf_we, rf_rd, rf_wdata,
        input  chk_hit, chk_data,
        input  wr_count, drop_count
    );

    modport slave (
        input  req0_valid, req0_rd, req0_data,
        input  req1_valid, req1_rd, req1_data,
        input  chk_rs,
        output req0_ready, req1_ready,
        output rf_we, rf_rd, rf_wdata,
        output chk_hit, chk_data,
        output wr_count, drop_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the integer register file write port.
// Requester 0 is the ALU/immediate path, requester 1 the load path. The
// granted write is registered onto the port one cycle later and exposed to
// the read side through a forwarding lookup.
module regfile_wb_arbiter #(
    parameter int XLEN = 64,
    parameter int AW   = 5,
    parameter int CW   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_wb_arbiter_if.slave   bus
);
    typedef enum logic {
        LAST_REQ0 = 1'b0,
        LAST_REQ1 = 1'b1
    } last_grant_e;

    last_grant_e     last_grant_q, last_grant_d;
    logic            rf_we_q, rf_we_d;
    logic [AW-1:0]   rf_rd_q, rf_rd_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [CW-1:0]   wr_count_q, wr_count_d;
    logic [CW-1:0]   drop_count_q, drop_count_d;

    logic            grant0;
    logic            grant1;
    logic [AW-1:0]   gnt_rd;
    logic [XLEN-1:0] gnt_data;
    logic            rf_we_out;

    // Arbitration: lone requester always wins; on contention the one not granted last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (bus.req0_valid && (!bus.req1_valid || last_grant_q == LAST_REQ1)) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
        gnt_rd   = grant0 ? bus.req0_rd   : bus.req1_rd;
        gnt_data = grant0 ? bus.req0_data : bus.req1_data;
    end

    // Next state of the output stage, round-robin pointer and counters.
    always_comb begin
        last_grant_d = last_grant_q;
        rf_we_d      = 1'b0;
        rf_rd_d      = rf_rd_q;
        rf_wdata_d   = rf_wdata_q;
        wr_count_d   = wr_count_q + {{(CW-1){1'b0}}, rf_we_q};
        drop_count_d = drop_count_q;
        if (grant0 || grant1) begin
            last_grant_d = grant0 ? LAST_REQ0 : LAST_REQ1;
            rf_rd_d      = gnt_rd;
            rf_wdata_d   = gnt_data;
            if (gnt_rd != '0) begin
                rf_we_d = 1'b1;
            end else begin
                drop_count_d = drop_count_q + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= LAST_REQ1;
            rf_we_q      <= 1'b0;
            rf_rd_q      <= '0;
            rf_wdata_q   <= '0;
            wr_count_q   <= '0;
            drop_count_q <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_rd_q      <= rf_rd_d;
            rf_wdata_q   <= rf_wdata_d;
            wr_count_q   <= wr_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    // A write already in the output stage when reset rises must not reach the
    // register file at the reset edge, so the enable is masked by reset.
    assign rf_we_out = rf_we_q & ~reset;

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rf_we      = rf_we_out;
    assign bus.rf_rd      = rf_rd_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.wr_count   = wr_count_q;
    assign bus.drop_count = drop_count_q;
    assign bus.chk_hit    = rf_we_out && (rf_rd_q == bus.chk_rs) && (bus.chk_rs != '0);
    assign bus.chk_data   = bus.chk_hit ? rf_wdata_q : '0;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter against a
// transaction-level model of the write-back port.
module tb_regfile_wb_arbiter;
    localparam int XLEN = 64;
    localparam int AW   = 5;
    localparam int CW   = 32;

    logic clk;
    logic reset;

    regfile_wb_arbiter_if #(.XLEN(XLEN), .AW(AW), .CW(CW)) bus ();

    regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model state: what the write port should show, and who won last.
    int          m_last;
    bit          m_we;
    logic [4:0]  m_rd;
    logic [63:0] m_wdata;
    logic [31:0] m_wr;
    logic [31:0] m_drop;

    logic [63:0] dut_regs [32];
    int          g_hist [$];
    bit          g0, g1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: check combinational outputs mid-cycle, then registered ones after the edge.
    task automatic cycle();
        bit          r;
        bit          hit;
        logic [4:0]  rd;
        logic [63:0] data;
        @(negedge clk);
        r  = reset;
        g0 = 1'b0;
        g1 = 1'b0;
        if (!r) begin
            if (bus.req1_valid && bus.req0_valid) begin
                if (m_last == 1) g0 = 1'b1; else g1 = 1'b1;
            end else begin
                g0 = bus.req0_valid;
                g1 = bus.req1_valid;
            end
        end
        check("req0_ready", bus.req0_ready, g0);
        check("req1_ready", bus.req1_ready, g1);
        hit = m_we && !r && (m_rd == bus.chk_rs) && (bus.chk_rs != 0);
        check("chk_hit", bus.chk_hit, hit);
        check("chk_data", bus.chk_data, hit ? m_wdata : 64'd0);
        if (bus.rf_we) dut_regs[bus.rf_rd] = bus.rf_wdata;
        if (bus.req0_ready) g_hist.push_back(0);
        if (bus.req1_ready) g_hist.push_back(1);
        @(posedge clk);
        #1;
        if (r) begin
            m_we = 0; m_rd = 0; m_wdata = 0; m_wr = 0; m_drop = 0; m_last = 1;
        end else begin
            if (m_we) m_wr = m_wr + 1;
            if (g0 || g1) begin
                rd      = g0 ? bus.req0_rd : bus.req1_rd;
                data    = g0 ? bus.req0_data : bus.req1_data;
                m_rd    = rd;
                m_wdata = data;
                m_last  = g0 ? 0 : 1;
                m_we    = (rd != 0);
                if (rd == 0) m_drop = m_drop + 1;
            end else begin
                m_we = 0;
            end
        end
        check("rf_we", bus.rf_we, m_we && !reset);
        check("rf_rd", bus.rf_rd, m_rd);
        check("rf_wdata", bus.rf_wdata, m_wdata);
        check("wr_count", bus.wr_count, m_wr);
        check("drop_count", bus.drop_count, m_drop);
    endtask

    task automatic idle();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc_n;
        bit          pend0, pend1;
        int          rs_list [3];
        m_last = 1; m_we = 0; m_rd = 0; m_wdata = 0; m_wr = 0; m_drop = 0;
        for (int i = 0; i < 32; i++) dut_regs[i] = '0;
        reset = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd1; bus.req0_data = 64'h1;
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd2; bus.req1_data = 64'h2;
        bus.chk_rs = 5'd0;
        // Reset with both requesters valid: readies must stay low.
        cycle();
        cycle();

        // Lone req0 write to x5.
        reset = 1'b0;
        idle();
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd5; bus.req0_data = 64'hA5A5A5A5A5A5A5A5;
        cycle();
        idle();
        bus.chk_rs = 5'd5;
        cycle();
        check("first_wr_count", bus.wr_count, 32'd1);
        check("x5_value", dut_regs[5], 64'hA5A5A5A5A5A5A5A5);

        // Sustained contention after reset: 0,1,0,1,0,1.
        do_reset();
        g_hist.delete();
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd3; bus.req0_data = 64'd1;
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd4; bus.req1_data = 64'd2;
        for (int i = 0; i < 6; i++) cycle();
        idle();
        cycle();
        check("contend_len", g_hist.size(), 6);
        for (int i = 0; i < 6 && i < g_hist.size(); i++) check("contend_order", g_hist[i], i % 2);

        // Write to x0 is acknowledged and dropped.
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd0; bus.req1_data = 64'hFFFFFFFFFFFFFFFF;
        cycle();
        idle();
        cycle();

        // Forwarding lookups: matching, non-matching, and x0.
        rs_list = '{10, 11, 0};
        for (int i = 0; i < 3; i++) begin
            bus.chk_rs = 5'd0;
            bus.req0_valid = 1'b1; bus.req0_rd = 5'd10; bus.req0_data = 64'h5A5A5A5A5A5A5A5A;
            cycle();
            idle();
            bus.chk_rs = 5'(rs_list[i]);
            cycle();
        end

        // Same destination from both in the first contest: final x7 is 0x22.
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd7; bus.req0_data = 64'h11;
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd7; bus.req1_data = 64'h22;
        cycle();
        check("same_rd_first", g0, 1'b1);
        bus.req0_valid = 1'b0;
        cycle();
        bus.req1_valid = 1'b0;
        cycle();
        cycle();
        check("x7_final", dut_regs[7], 64'h22);

        // Reset right after a grant to x9 kills the write.
        do_reset();
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        bus.req0_rd = 5'd1; bus.req1_rd = 5'd2;
        cycle();                       // req0 wins; last grant now req0
        idle();
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd9; bus.req1_data = 64'h99;
        cycle();
        idle();
        reset = 1'b1;
        bus.chk_rs = 5'd9;
        cycle();
        reset = 1'b0;
        check("x9_never_written", dut_regs[9], 64'd0);
        check("rst_wr_count", bus.wr_count, 32'd0);
        g_hist.delete();
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        cycle();
        idle();
        check("post_reset_first", g_hist.size() > 0 ? g_hist[0] : -1, 0);

        // Randomized traffic with held handshakes and occasional reset.
        pend0 = 0; pend1 = 0;
        for (cyc_n = 0; cyc_n < 400; cyc_n++) begin
            reset = ($urandom_range(0, 99) < 3);
            if (!pend0 && $urandom_range(0, 99) < 60) begin
                pend0 = 1;
                bus.req0_rd   = 5'($urandom_range(0, 7));
                bus.req0_data = {$urandom(), $urandom()};
            end
            if (!pend1 && $urandom_range(0, 99) < 60) begin
                pend1 = 1;
                bus.req1_rd   = 5'($urandom_range(0, 7));
                bus.req1_data = {$urandom(), $urandom()};
            end
            bus.req0_valid = pend0;
            bus.req1_valid = pend1;
            bus.chk_rs = 5'($urandom_range(0, 7));
            cycle();
            if (g0) pend0 = 0;
            if (g1) pend1 = 0;
        end
        reset = 1'b0;
        idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and sequencer for the 64-bit, 32-entry integer register file. It shares the register file's single write port between two write-back requesters: requester 0 is the ALU/immediate path and requester 1 is the load/memory path. Grants use round-robin on contention, and each granted write is registered onto the write port one cycle later. A forwarding lookup exposes the in-flight write so read-side logic can bypass it.

## Interface
- XLEN, 64, data width of the register file
- AW, 5, register address width (32 registers; x0 hard-wired zero)
- CW, 32, width of the statistics counters

- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a write pending
- req0_rd  in  AW  requester 0 destination register
- req0_data  in  XLEN  requester 0 write data
- req0_ready  out  1  requester 0 accepted this cycle (combinational)
- req1_valid  in  1  requester 1 has a write pending
- req1_rd  in  AW  requester 1 destination register
- req1_data  in  XLEN  requester 1 write data
- req1_ready  out  1  requester 1 accepted this cycle (combinational)
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  AW  register-file write address (registered)
- rf_wdata  out  XLEN  register-file write data (registered)
- chk_rs  in  AW  forwarding lookup address
- chk_hit  out  1  the in-flight write targets chk_rs (combinational)
- chk_data  out  XLEN  forwarded data; equals rf_wdata when chk_hit, else 0
- wr_count  out  CW  number of committed writes (rf_we pulses)
- drop_count  out  CW  number of accepted writes to x0 that were discarded

## Operation
- Handshake: a requester raises valid and holds valid/rd/data stable until it sees ready high at a rising edge. A transfer occurs when valid&ready are both high at the edge.
- At most one grant per cycle. The write port never back-pressures, so a lone valid requester is always granted in the same cycle.
- Contention (both valid): the requester that was not granted most recently wins. The last_grant register updates on every grant. It resets to 1, so req0 wins the first contest.
- The loser keeps valid high and is granted next cycle, unless the winner re-requests and the round-robin order says otherwise. Two back-to-back contending requesters alternate 0,1,0,1.
- Output stage: on a grant, rf_rd ← granted rd and rf_wdata ← granted data. rf_we ← 1 only if rd ≠ 0.
- A granted write with rd = 0 is acknowledged (ready high) but produces no rf_we. drop_count increments by 1.
- With no grant, rf_we ← 0 on the next edge. rf_rd and rf_wdata hold their last values.
- wr_count increments on every cycle in which rf_we is high.
- Both counters wrap modulo 2^CW with no saturation.
- Forwarding: chk_hit = rf_we & (rf_rd == chk_rs) & (chk_rs ≠ 0). chk_data = chk_hit ? rf_wdata : 0.
- Same rd from both requesters in one cycle: the writes are serialized in grant order, so the later grant's data is the final register value.
- Reset (synchronous, any cycle) clears the following on the next edge:
  - rf_we, rf_rd and rf_wdata to 0
  - wr_count and drop_count to 0
  - last_grant to 1
- While reset is high, req0_ready = req1_ready = 0. A write in flight in the output stage is discarded and never committed.

## Timing
- Reset values: rf_we=0, rf_rd=0, rf_wdata=0, wr_count=0, drop_count=0, chk_hit=0, chk_data=0; ready outputs low during reset.
- Grant latency: 0 cycles. ready is combinational from valid and last_grant, with no dependency on the rf_* outputs.
- Write latency: if the transfer occurs at edge N, rf_we is high during cycle N+1 and the register file updates at edge N+1.
- Throughput: one write per cycle sustained.
- Worst-case wait for a continuously valid requester: 1 cycle.
- Counters update at the edge ending the cycle of their event:
  - wr_count changes at edge N+1.
  - drop_count changes at edge N.

## Test plan
- Reset, then req0 alone with rd=5 and data=A5A5A5A5A5A5A5A5 for one cycle. Required: req0_ready=1 that cycle; the next cycle shows rf_we=1, rf_rd=5, rf_wdata=A5A5…; wr_count=1 afterwards.
- After reset, req0 (rd=3, data=1) and req1 (rd=4, data=2) both valid and held. Required grant order: req0 then req1, on consecutive cycles, giving rf writes x3 then x4. A sustained contention of 6 cycles grants 0,1,0,1,0,1.
- req1 with rd=0 and data=FFFFFFFFFFFFFFFF. Required: req1_ready=1, rf_we stays 0, drop_count=1, wr_count unchanged.
- req0 (rd=10, data=5A5A…) granted, with chk_rs=10 during the following cycle. Required: chk_hit=1 and chk_data=5A5A…. With chk_rs=11 or chk_rs=0 instead, required: chk_hit=0 and chk_data=0.
- Both requesters target rd=7 with data 0x11 and 0x22 in the first post-reset contest. Required rf writes: 0x11 then 0x22, so the final x7 value is 0x22.
- Assert reset in the cycle after a grant to rd=9. Required: rf_we=0 at the next edge (x9 is never written), both counters 0, and the next contention goes to req0 first.
